wb_buf: RTL and testbench

WB_BUF -- requirements
Module: wb_buf

---
 rtl/wb_buf.sv | 109 ++++++++++
 tb/tb_wb_buf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_buf.sv
// Writeback buffer: circular FIFO of {rd, data} between the ALU and the register-file write port.
// Optional operand bypass lookup is compiled in when WB_BUF_BYPASS_EN is defined.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module wb_buf #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned REG_SEL_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset_x,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_SEL_WIDTH-1:0] in_rd,
  input  logic [`DATA_LEN-1:0]     in_data,
  input  logic                     rf_busy,
  output logic                     rf_we,
  output logic [REG_SEL_WIDTH-1:0] rf_waddr,
  output logic [`DATA_LEN-1:0]     rf_wdata,
  input  logic [REG_SEL_WIDTH-1:0] rs1_addr,
  input  logic [REG_SEL_WIDTH-1:0] rs2_addr,
  output logic                     rs1_hit,
  output logic                     rs2_hit,
  output logic [`DATA_LEN-1:0]     rs1_fwd,
  output logic [`DATA_LEN-1:0]     rs2_fwd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = `DATA_LEN;

  logic [REG_SEL_WIDTH-1:0] r_rd   [DEPTH];
  logic [DW-1:0]            r_data [DEPTH];
  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [CW-1:0]            r_count;

  logic w_push;
  logic w_pop;

  // Handshake and drain are decoded from occupancy only, so no in_* -> rf_* path exists.
  assign in_ready = (r_count != CW'(DEPTH));
  assign w_push   = in_valid && in_ready && (in_rd != '0);
  assign w_pop    = (r_count != '0) && !rf_busy;
  assign rf_we    = w_pop;
  assign rf_waddr = w_pop ? r_rd[r_head]   : '0;
  assign rf_wdata = w_pop ? r_data[r_head] : '0;
  assign count    = r_count;

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is qualified by occupancy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= in_rd;
      r_data[r_tail] <= in_data;
    end
  end

`ifdef WB_BUF_BYPASS_EN
  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    rs1_fwd = '0;
    rs2_fwd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = r_head + PW'(i);
      if (CW'(i) < r_count) begin
        if ((rs1_addr != '0) && (r_rd[idx] == rs1_addr)) begin
          rs1_hit = 1'b1;
          rs1_fwd = r_data[idx];
        end
        if ((rs2_addr != '0) && (r_rd[idx] == rs2_addr)) begin
          rs2_hit = 1'b1;
          rs2_fwd = r_data[idx];
        end
      end
    end
  end
`else
  logic w_unused_rs;
  assign w_unused_rs = ^{rs1_addr, rs2_addr};
  assign rs1_hit     = 1'b0;
  assign rs2_hit     = 1'b0;
  assign rs1_fwd     = '0;
  assign rs2_fwd     = '0;
`endif

endmodule

// File: tb/tb_wb_buf.sv
// Bench for wb_buf: directed scenarios plus random traffic against a queue-based reference model.
// Bypass expectations follow WB_BUF_BYPASS_EN.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module tb_wb_buf;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RSW   = 5;
  localparam int unsigned DW    = `DATA_LEN;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef WB_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [RSW-1:0] rd;
    logic [DW-1:0]  data;
  } ent_t;

  logic           clk = 1'b0;
  logic           reset_x;
  logic           in_valid;
  logic           in_ready;
  logic [RSW-1:0] in_rd;
  logic [DW-1:0]  in_data;
  logic           rf_busy;
  logic           rf_we;
  logic [RSW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [RSW-1:0] rs1_addr;
  logic [RSW-1:0] rs2_addr;
  logic           rs1_hit;
  logic           rs2_hit;
  logic [DW-1:0]  rs1_fwd;
  logic [DW-1:0]  rs2_fwd;
  logic [CW-1:0]  count;

  wb_buf #(.DEPTH(DEPTH), .REG_SEL_WIDTH(RSW)) dut (
    .clk(clk), .reset_x(reset_x),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .rf_busy(rf_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_hit(rs1_hit), .rs2_hit(rs2_hit), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .count(count)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic e_ready;
  logic e_we;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Youngest pending write to addr, judged from the model queue.
  task automatic lookup(input logic [RSW-1:0] addr, output logic hit, output logic [DW-1:0] fwd);
    hit = 1'b0;
    fwd = '0;
    if (BYP && addr != '0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].rd == addr) begin
          hit = 1'b1;
          fwd = q[i].data;
          break;
        end
      end
    end
  endtask

  // Drive one cycle's inputs between edges and compare every output against the model.
  task automatic drive(input logic v, input logic [RSW-1:0] rd, input logic [DW-1:0] d,
                       input logic busy, input logic [RSW-1:0] a1, input logic [RSW-1:0] a2);
    logic h1, h2;
    logic [DW-1:0] f1, f2;
    @(negedge clk);
    in_valid = v; in_rd = rd; in_data = d; rf_busy = busy; rs1_addr = a1; rs2_addr = a2;
    #1;
    e_ready = (q.size() != DEPTH);
    e_we    = (q.size() != 0) && !busy;
    check("in_ready", 64'(in_ready), 64'(e_ready));
    check("count", 64'(count), 64'(q.size()));
    check("rf_we", 64'(rf_we), 64'(e_we));
    check("rf_waddr", 64'(rf_waddr), e_we ? 64'(q[0].rd) : 64'd0);
    check("rf_wdata", 64'(rf_wdata), e_we ? 64'(q[0].data) : 64'd0);
    lookup(a1, h1, f1);
    lookup(a2, h2, f2);
    check("rs1_hit", 64'(rs1_hit), 64'(h1));
    check("rs1_fwd", 64'(rs1_fwd), 64'(f1));
    check("rs2_hit", 64'(rs2_hit), 64'(h2));
    check("rs2_fwd", 64'(rs2_fwd), 64'(f2));
  endtask

  // Advance the model across the clock edge using the expectations of the current cycle.
  task automatic tick();
    logic acc;
    acc = in_valid && e_ready && (in_rd != '0);
    @(posedge clk);
    if (e_we) void'(q.pop_front());
    if (acc) q.push_back('{rd: in_rd, data: in_data});
  endtask

  task automatic cyc(input logic v, input logic [RSW-1:0] rd, input logic [DW-1:0] d,
                     input logic busy, input logic [RSW-1:0] a1, input logic [RSW-1:0] a2);
    drive(v, rd, d, busy, a1, a2);
    tick();
  endtask

  initial begin
    reset_x = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
    rf_busy = 1'b0; rs1_addr = '0; rs2_addr = '0;
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    #4 reset_x = 1'b1;

    // Single write with one-cycle latency.
    cyc(1'b1, RSW'(5), DW'(32'h1234), 1'b0, '0, '0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    check("single_we", 64'(rf_we), 64'd1);
    check("single_waddr", 64'(rf_waddr), 64'd5);
    check("single_wdata", 64'(rf_wdata), 64'h1234);
    tick();
    cyc(1'b0, '0, '0, 1'b0, '0, '0);

    // Fill to DEPTH while the port is busy, then drain in order while rd=5 waits.
    for (int r = 1; r <= 4; r++) cyc(1'b1, RSW'(r), DW'(32'h100 + r), 1'b1, '0, '0);
    drive(1'b1, RSW'(5), DW'(32'h105), 1'b1, '0, '0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(count), 64'(DEPTH));
    tick();
    for (int k = 0; k < 8; k++) cyc(1'b1, RSW'(5), DW'(32'h105), 1'b0, '0, '0);
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, '0, 1'b0, '0, '0);

    // x0 destination is accepted and dropped.
    drive(1'b1, '0, DW'(32'hFFFF), 1'b0, '0, '0);
    check("x0_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    check("x0_count", 64'(count), 64'd0);
    check("x0_we", 64'(rf_we), 64'd0);
    tick();

    // Youngest match wins; the entry being offered this cycle is not searched.
    cyc(1'b1, RSW'(7), DW'(32'hA), 1'b1, '0, '0);
    cyc(1'b1, RSW'(7), DW'(32'hB), 1'b1, RSW'(7), '0);
    drive(1'b1, RSW'(7), DW'(32'hC), 1'b1, RSW'(7), RSW'(3));
    check("byp_rs1_hit", 64'(rs1_hit), 64'(BYP));
    check("byp_rs1_fwd", 64'(rs1_fwd), BYP ? 64'hB : 64'd0);
    check("byp_rs2_hit", 64'(rs2_hit), 64'd0);
    tick();
    for (int k = 0; k < 5; k++) cyc(1'b0, '0, '0, 1'b0, RSW'(7), '0);

    // Steady count of two with enqueue and dequeue every cycle, wrapping the pointers.
    cyc(1'b1, RSW'(9), DW'(32'h900), 1'b1, '0, '0);
    cyc(1'b1, RSW'(10), DW'(32'h901), 1'b1, '0, '0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, RSW'(11 + k), DW'(32'h902 + k), 1'b0, RSW'(11 + k), RSW'(10 + k));
      check("wrap_count", 64'(count), 64'd2);
      tick();
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset pulse between edges with three entries pending.
    for (int r = 1; r <= 3; r++) cyc(1'b1, RSW'(r + 20), DW'(32'h300 + r), 1'b1, '0, '0);
    @(negedge clk);
    in_valid = 1'b0; rf_busy = 1'b0; rs1_addr = RSW'(21); rs2_addr = RSW'(22);
    #1 reset_x = 1'b0;
    #1;
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_we", 64'(rf_we), 64'd0);
    check("mrst_waddr", 64'(rf_waddr), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd1);
    check("mrst_rs1_hit", 64'(rs1_hit), 64'd0);
    check("mrst_rs2_fwd", 64'(rs2_fwd), 64'd0);
    q.delete();
    #1 reset_x = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, '0, 1'b0, RSW'(21), RSW'(23));

    // Random traffic; small register range makes bypass matches common.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(0, 1)), RSW'($urandom_range(0, 7)), DW'($urandom),
          ($urandom_range(0, 9) < 4), RSW'($urandom_range(0, 7)), RSW'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
